div: RTL

- Multi-cycle 32-bit signed/unsigned integer divider for DIV/DIVU in the EX stage.
- EX holds start_i high and raises its stall request to the pipeline controller until ready_o is seen, which freezes PC/IF/ID/EX.
- Result is written to HI/LO: HI = remainder, LO = quotient.
- Radix-2 restoring algorithm, one quotient bit per cycle.

---
 rtl/div.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/div.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU: HI = remainder, LO = quotient.
// Latency 33 edges (2 for a zero divisor). The result is held while start_i stays high and annul_i aborts the divide.
module div #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               start_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o
);

    typedef enum logic [1:0] {
        ST_FREE    = 2'd0,
        ST_BY_ZERO = 2'd1,
        ST_ON      = 2'd2,
        ST_END     = 2'd3
    } state_e;

    localparam logic [5:0] LAST_CNT = 6'(WIDTH);

    state_e             state_q, state_d;
    logic [5:0]         cnt_q, cnt_d;
    logic [2*WIDTH:0]   dividend_q, dividend_d;
    logic [WIDTH-1:0]   op2_abs_q, op2_abs_d;
    logic               signed_q, signed_d;
    logic               sign1_q, sign1_d;
    logic               sign2_q, sign2_d;
    logic [2*WIDTH-1:0] result_q, result_d;
    logic               ready_q, ready_d;

    logic [WIDTH-1:0]   op1_abs, op2_abs;
    logic [WIDTH:0]     diff;
    logic [WIDTH-1:0]   quot_raw, rem_raw, quot_fin, rem_fin;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_FREE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FREE: begin
                if (start_i && !annul_i) begin
                    state_d = (opdata2_i == '0) ? ST_BY_ZERO : ST_ON;
                end
            end
            ST_BY_ZERO: state_d = ST_END;
            ST_ON: begin
                if (annul_i) begin
                    state_d = ST_FREE;
                end else if (cnt_q == LAST_CNT) begin
                    state_d = ST_END;
                end
            end
            ST_END: begin
                if (!start_i) begin
                    state_d = ST_FREE;
                end
            end
            default: state_d = ST_FREE;
        endcase
    end

    // Magnitudes: 0x80000000 negates to itself, which reads correctly as unsigned 2^31.
    assign op1_abs = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
    assign op2_abs = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;

    assign diff     = {1'b0, dividend_q[2*WIDTH-1:WIDTH]} - {1'b0, op2_abs_q};
    assign quot_raw = dividend_q[WIDTH-1:0];
    assign rem_raw  = dividend_q[2*WIDTH:WIDTH+1];
    assign quot_fin = (signed_q && (sign1_q ^ sign2_q)) ? -quot_raw : quot_raw;
    assign rem_fin  = (signed_q && sign1_q) ? -rem_raw : rem_raw;

    always_comb begin
        cnt_d      = cnt_q;
        dividend_d = dividend_q;
        op2_abs_d  = op2_abs_q;
        signed_d   = signed_q;
        sign1_d    = sign1_q;
        sign2_d    = sign2_q;
        result_d   = '0;
        ready_d    = 1'b0;
        case (state_q)
            ST_FREE: begin
                if (start_i && !annul_i && (opdata2_i != '0)) begin
                    cnt_d      = '0;
                    dividend_d = {{WIDTH{1'b0}}, op1_abs, 1'b0};
                    op2_abs_d  = op2_abs;
                    signed_d   = signed_div_i;
                    sign1_d    = opdata1_i[WIDTH-1];
                    sign2_d    = opdata2_i[WIDTH-1];
                end
            end
            ST_BY_ZERO: dividend_d = '0;
            ST_ON: begin
                if (!annul_i) begin
                    if (cnt_q != LAST_CNT) begin
                        cnt_d = cnt_q + 6'd1;
                        if (diff[WIDTH]) begin
                            dividend_d = {dividend_q[2*WIDTH-1:0], 1'b0};
                        end else begin
                            dividend_d = {diff[WIDTH-1:0], dividend_q[WIDTH-1:0], 1'b1};
                        end
                    end else begin
                        // Keep the signed-corrected result in the working register so END can replay it.
                        dividend_d = {rem_fin, 1'b0, quot_fin};
                        result_d   = {rem_fin, quot_fin};
                        ready_d    = 1'b1;
                    end
                end
            end
            ST_END: begin
                if (start_i) begin
                    result_d = {dividend_q[2*WIDTH:WIDTH+1], dividend_q[WIDTH-1:0]};
                    ready_d  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= '0;
            dividend_q <= '0;
            op2_abs_q  <= '0;
            signed_q   <= 1'b0;
            sign1_q    <= 1'b0;
            sign2_q    <= 1'b0;
            result_q   <= '0;
            ready_q    <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            dividend_q <= dividend_d;
            op2_abs_q  <= op2_abs_d;
            signed_q   <= signed_d;
            sign1_q    <= sign1_d;
            sign2_q    <= sign2_d;
            result_q   <= result_d;
            ready_q    <= ready_d;
        end
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;

endmodule
